// File: rtl/cpu_pkg.sv
// Shared core definitions: instruction field layout, special register ids,
// opcode classes and the hazard FSM state encoding.
package cpu_pkg;
  localparam int IMB_BIT = 31;
  localparam int RA_HI   = 30;
  localparam int RA_LO   = 27;
  localparam int RB_HI   = 26;
  localparam int RB_LO   = 23;
  localparam int OPC_HI  = 12;
  localparam int OPC_LO  = 8;
  localparam int RC_HI   = 7;
  localparam int RC_LO   = 4;
  localparam int CMP_BIT = 0;

  localparam logic [3:0] REG_PC  = 4'hE;
  localparam logic [3:0] REG_OVF = 4'hF;
  localparam int         OVF_BIT = 15;

  localparam logic [4:0] OPC_ADD   = 5'h00;
  localparam logic [4:0] OPC_SUB   = 5'h01;
  localparam logic [4:0] OPC_MUL   = 5'h02;
  localparam logic [4:0] OPC_STORE = 5'h10;

  typedef logic [1:0] hz_state_t;
  localparam hz_state_t RUN     = 2'd0;
  localparam hz_state_t WAIT_PC = 2'd1;
  localparam hz_state_t FLUSH   = 2'd2;

  // Arithmetic ops that can overflow update the overflow register.
  function automatic logic writes_ovf(input logic [4:0] opc);
    return (opc == OPC_ADD) || (opc == OPC_SUB) || (opc == OPC_MUL);
  endfunction
endpackage

// File: rtl/hazard_control_if.sv
// Decode-stage issue/retire bundle between the pipeline and hazard_control.
interface hazard_control_if;
  logic [31:0] instr_dec;
  logic        mem_busy;
  logic        wb_valid;
  logic [3:0]  wb_rc;
  logic        wb_ovf;
  logic        stall;
  logic        flush;
  logic [15:0] sb_pending;
  logic [31:0] stall_count;

  modport master (
    output instr_dec, mem_busy, wb_valid, wb_rc, wb_ovf,
    input  stall, flush, sb_pending, stall_count
  );
  modport slave (
    input  instr_dec, mem_busy, wb_valid, wb_rc, wb_ovf,
    output stall, flush, sb_pending, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set on issue,
// cleared on retire. Bit 14 (PC) is never tracked.
module hazard_scoreboard
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] set_mask,
  input  logic [15:0] clr_mask,
  output logic [15:0] pending
);
  logic [15:0] pend_q, pend_d;

  always_comb begin
    pend_d         = (pend_q & ~clr_mask) | set_mask;
    pend_d[REG_PC] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  assign pending = pend_q;
endmodule

// File: rtl/hazard_control.sv
// Decode-stage issue control: RAW/WAW/memory/PC-write stalls, scoreboard
// update, post-jump flush sequencing and a stall cycle counter.
module hazard_control
  import cpu_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  hazard_control_if.slave  hif
);
  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

  logic [31:0] instr;
  logic        bubble, imb, cmp;
  logic [3:0]  ra, rb, rc;
  logic [4:0]  opc;
  logic        wr_rc, pc_wr, hazard, stall, issue;
  logic [15:0] src_mask, dst_mask, set_mask, clr_mask, pend;
  logic        unused_fields;

  hz_state_t   state_q, state_d;
  logic [2:0]  fcnt_q, fcnt_d;
  logic        flush_q, flush_d;
  logic [31:0] scnt_q, scnt_d;

  assign instr  = hif.instr_dec;
  assign bubble = (instr == 32'h0);
  assign imb    = instr[IMB_BIT];
  assign ra     = instr[RA_HI:RA_LO];
  assign rb     = instr[RB_HI:RB_LO];
  assign opc    = instr[OPC_HI:OPC_LO];
  assign rc     = instr[RC_HI:RC_LO];
  assign cmp    = instr[CMP_BIT];
  assign unused_fields = ^{instr[22:13], instr[3:1]};

  // Source/destination masks; Ra = F naturally lands on the overflow bit.
  always_comb begin
    src_mask = '0;
    dst_mask = '0;
    if (ra != REG_PC)             src_mask[ra] = 1'b1;
    if (!imb && (rb < REG_PC))    src_mask[rb] = 1'b1;
    wr_rc = !bubble && !cmp && (opc != OPC_STORE) && (rc != REG_OVF);
    pc_wr = wr_rc && (rc == REG_PC);
    if (wr_rc && !pc_wr)          dst_mask[rc] = 1'b1;
    if (!bubble && writes_ovf(opc)) dst_mask[OVF_BIT] = 1'b1;
  end

  // No retire bypass: hazards are judged on the registered scoreboard only.
  assign hazard = (|(src_mask & pend)) | (|(dst_mask & pend));
  assign stall  = !rst && !bubble && (hif.mem_busy || hazard || (state_q != RUN));
  assign issue  = !bubble && !stall && !flush_q;

  always_comb begin
    set_mask = issue ? dst_mask : '0;
    clr_mask = '0;
    if (hif.wb_valid) begin
      if (hif.wb_rc < REG_PC) clr_mask[hif.wb_rc] = 1'b1;
      if (hif.wb_ovf)         clr_mask[OVF_BIT]   = 1'b1;
    end
  end

  hazard_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_mask (set_mask),
    .clr_mask (clr_mask),
    .pending  (pend)
  );

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      RUN:     if (issue && pc_wr) state_d = WAIT_PC;
      WAIT_PC: if (hif.wb_valid && (hif.wb_rc == REG_PC)) begin
                 state_d = FLUSH;
                 fcnt_d  = FLUSH_LAST;
               end
      FLUSH:   if (fcnt_q == 3'd0) state_d = RUN;
               else                fcnt_d  = fcnt_q - 3'd1;
      default: state_d = RUN;
    endcase
    flush_d = (state_d == FLUSH);
    scnt_d  = stall ? scnt_q + 32'd1 : scnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      fcnt_q  <= '0;
      flush_q <= 1'b0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      flush_q <= flush_d;
      scnt_q  <= scnt_d;
    end
  end

  assign hif.stall       = stall;
  assign hif.flush       = flush_q;
  assign hif.sb_pending  = pend;
  assign hif.stall_count = scnt_q;
endmodule

// File: tb/tb_hazard_control.sv
// Bench for hazard_control: directed scenarios plus randomized traffic,
// checked against a cycle-level behavioural model of the issue rules.
module tb_hazard_control;
  localparam int FC = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  hazard_control_if hif ();

  hazard_control #(.FLUSH_CYCLES(FC)) dut (
    .clk (clk),
    .rst (rst),
    .hif (hif.slave)
  );

  always #5 clk = ~clk;

  // Model state: pending registers, mode (0 run, 1 waiting on PC, 2 flushing)
  bit [15:0]   m_pend;
  int          m_mode;
  int          m_left;
  int unsigned m_cnt;
  bit          m_stall, m_issue;

  function automatic logic [31:0] mk(input bit imb, input int ra, input int rb,
                                     input int opc, input int rc, input bit cmp);
    logic [31:0] i;
    i = '0;
    i[31] = imb; i[30:27] = 4'(ra); i[26:23] = 4'(rb);
    i[12:8] = 5'(opc); i[7:4] = 4'(rc); i[0] = cmp;
    return i;
  endfunction

  function automatic void m_decode(input logic [31:0] i, output bit [15:0] rd,
                                   output bit [15:0] wr, output bit pcw);
    int ra, rb, rc, opc;
    ra = int'(i[30:27]); rb = int'(i[26:23]); rc = int'(i[7:4]); opc = int'(i[12:8]);
    rd = '0; wr = '0; pcw = 1'b0;
    if (i == 32'h0) return;
    if (ra != 14) rd[ra] = 1'b1;
    if (!i[31] && rb < 14) rd[rb] = 1'b1;
    if (!i[0] && opc != 16 && rc != 15) begin
      if (rc == 14) pcw = 1'b1;
      else          wr[rc] = 1'b1;
    end
    if (opc <= 2) wr[15] = 1'b1;
  endfunction

  task automatic m_eval();
    bit [15:0] rd, wr; bit pcw, bub;
    m_decode(hif.instr_dec, rd, wr, pcw);
    bub = (hif.instr_dec == 32'h0);
    if (rst) begin m_stall = 0; m_issue = 0; end
    else begin
      m_stall = !bub && (hif.mem_busy || ((rd & m_pend) != 0) || ((wr & m_pend) != 0) || m_mode != 0);
      m_issue = !bub && !m_stall && m_mode != 2;
    end
  endtask

  task automatic drive(input logic [31:0] i, input logic mb, input logic wv,
                       input logic [3:0] rc, input logic ovf);
    hif.instr_dec = i; hif.mem_busy = mb; hif.wb_valid = wv; hif.wb_rc = rc; hif.wb_ovf = ovf;
    #1;
    m_eval();
  endtask

  task automatic tick();
    bit [15:0] rd, wr, clr; bit pcw;
    m_eval();
    @(posedge clk);
    if (rst) begin
      m_pend = '0; m_mode = 0; m_left = 0; m_cnt = 0;
    end else begin
      m_decode(hif.instr_dec, rd, wr, pcw);
      clr = '0;
      if (hif.wb_valid) begin
        if (hif.wb_rc < 14) clr[hif.wb_rc] = 1'b1;
        if (hif.wb_ovf)     clr[15] = 1'b1;
      end
      checks++;
      if (m_issue && (wr & clr) != 0) begin
        errors++; $display("FAIL set_clr_same_bit bits=%h required=0000", wr & clr);
      end
      if (m_stall) m_cnt++;
      case (m_mode)
        0: if (m_issue && pcw) m_mode = 1;
        1: if (hif.wb_valid && hif.wb_rc == 4'hE) begin m_mode = 2; m_left = FC; end
        default: begin m_left--; if (m_left == 0) m_mode = 0; end
      endcase
      m_pend = (m_pend & ~clr) | (m_issue ? wr : 16'h0);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(mk(0, 1, 2, 0, 3, 0), 1'b1, 1'b0, 4'h0, 1'b0);
    checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL rst_stall got=%b required=0", hif.stall); end
    tick(); tick();
    checks++; if (hif.sb_pending !== 16'h0) begin errors++; $display("FAIL rst_sb got=%h required=0000", hif.sb_pending); end
    checks++; if (hif.flush !== 1'b0) begin errors++; $display("FAIL rst_flush got=%b required=0", hif.flush); end
    checks++; if (hif.stall_count !== 32'h0) begin errors++; $display("FAIL rst_count got=%0d required=0", hif.stall_count); end
    rst = 1'b0;
    drive(32'h0, 1'b0, 1'b0, 4'h0, 1'b0); tick();
  endtask

  task automatic test_raw();
    drive(mk(1, 14, 0, 3, 3, 0), 0, 0, 0, 0);
    checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL raw_producer_stall got=%b required=0", hif.stall); end
    tick();
    checks++; if (hif.sb_pending !== 16'h0008) begin errors++; $display("FAIL raw_sb_set got=%h required=0008", hif.sb_pending); end
    for (int c = 0; c < 4; c++) begin
      drive(mk(1, 3, 0, 3, 4, 0), 0, (c == 3), 4'h3, 0);
      checks++; if (hif.stall !== 1'b1) begin errors++; $display("FAIL raw_consumer_stall cyc=%0d got=%b required=1", c, hif.stall); end
      tick();
    end
    drive(mk(1, 3, 0, 3, 4, 0), 0, 0, 0, 0);
    checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL raw_release got=%b required=0", hif.stall); end
    tick();
    checks++; if (hif.sb_pending !== 16'h0010) begin errors++; $display("FAIL raw_sb_after got=%h required=0010", hif.sb_pending); end
    drive(32'h0, 0, 1, 4'h4, 0); tick();
  endtask

  task automatic test_imm();
    drive(mk(1, 14, 0, 3, 3, 0), 0, 0, 0, 0); tick();
    drive(mk(1, 14, 3, 3, 5, 0), 0, 0, 0, 0);
    checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL imm_no_stall got=%b required=0", hif.stall); end
    tick();
    drive(mk(0, 14, 3, 3, 6, 0), 0, 0, 0, 0);
    checks++; if (hif.stall !== 1'b1) begin errors++; $display("FAIL reg_rb_stall got=%b required=1", hif.stall); end
    drive(32'h0, 0, 1, 4'h3, 0); tick();
    drive(32'h0, 0, 1, 4'h5, 0); tick();
    checks++; if (hif.sb_pending !== 16'h0) begin errors++; $display("FAIL imm_sb_clean got=%h required=0000", hif.sb_pending); end
  endtask

  task automatic test_jump();
    drive(mk(1, 14, 0, 3, 14, 0), 0, 0, 0, 0);
    checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL jump_issue got=%b required=0", hif.stall); end
    tick();
    for (int c = 0; c < 4; c++) begin
      drive(mk(1, 14, 0, 3, 1, 0), 0, (c == 3), 4'hE, 0);
      checks++; if (hif.stall !== 1'b1 || hif.flush !== 1'b0) begin
        errors++; $display("FAIL jump_wait cyc=%0d stall=%b flush=%b required stall=1 flush=0", c, hif.stall, hif.flush); end
      tick();
    end
    for (int c = 0; c < FC; c++) begin
      drive(mk(1, 14, 0, 3, 1, 0), 0, 0, 0, 0);
      checks++; if (hif.flush !== 1'b1 || hif.stall !== 1'b1) begin
        errors++; $display("FAIL jump_flush cyc=%0d flush=%b stall=%b required 1 1", c, hif.flush, hif.stall); end
      tick();
    end
    drive(mk(1, 14, 0, 3, 1, 0), 0, 0, 0, 0);
    checks++; if (hif.flush !== 1'b0 || hif.stall !== 1'b0) begin
      errors++; $display("FAIL jump_resume flush=%b stall=%b required 0 0", hif.flush, hif.stall); end
    tick();
    drive(32'h0, 0, 1, 4'h1, 0); tick();
  endtask

  task automatic test_mem_busy();
    int unsigned base;
    base = hif.stall_count;
    for (int c = 0; c < 5; c++) begin
      drive(mk(1, 14, 0, 3, 2, 1), 1, 0, 0, 0);
      checks++; if (hif.stall !== 1'b1) begin errors++; $display("FAIL mem_busy_stall cyc=%0d got=%b required=1", c, hif.stall); end
      tick();
    end
    drive(mk(1, 14, 0, 3, 2, 1), 0, 0, 0, 0);
    checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL mem_free got=%b required=0", hif.stall); end
    checks++; if (hif.stall_count !== base + 5) begin errors++; $display("FAIL mem_count got=%0d required=%0d", hif.stall_count, base + 5); end
    tick();
  endtask

  task automatic test_ovf();
    drive(mk(1, 14, 0, 0, 1, 0), 0, 0, 0, 0); tick();
    checks++; if (hif.sb_pending !== 16'h8002) begin errors++; $display("FAIL ovf_set got=%h required=8002", hif.sb_pending); end
    drive(mk(1, 15, 0, 3, 2, 0), 0, 1, 4'h1, 0);
    checks++; if (hif.stall !== 1'b1) begin errors++; $display("FAIL ovf_read_stall got=%b required=1", hif.stall); end
    tick();
    drive(mk(1, 15, 0, 3, 2, 0), 0, 1, 4'hF, 1);
    checks++; if (hif.stall !== 1'b1) begin errors++; $display("FAIL ovf_no_bypass got=%b required=1", hif.stall); end
    tick();
    drive(mk(1, 15, 0, 3, 2, 0), 0, 0, 0, 0);
    checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL ovf_release got=%b required=0", hif.stall); end
    tick();
    drive(mk(1, 14, 0, 3, 5, 0), 0, 1, 4'h2, 0); tick();
    checks++; if (hif.sb_pending !== 16'h0020) begin errors++; $display("FAIL set_clr_mix got=%h required=0020", hif.sb_pending); end
    drive(32'h0, 0, 1, 4'h5, 0); tick();
  endtask

  task automatic test_reset_mid();
    drive(mk(1, 14, 0, 3, 1, 0), 0, 0, 0, 0); tick();
    drive(mk(1, 14, 0, 3, 7, 0), 0, 0, 0, 0); tick();
    drive(mk(1, 14, 0, 3, 14, 0), 0, 0, 0, 0); tick();
    drive(mk(1, 14, 0, 3, 9, 0), 0, 0, 0, 0);
    checks++; if (hif.stall !== 1'b1 || hif.sb_pending !== 16'h0082) begin
      errors++; $display("FAIL pre_reset stall=%b sb=%h required 1 0082", hif.stall, hif.sb_pending); end
    rst = 1'b1; drive(mk(1, 14, 0, 3, 9, 0), 0, 0, 0, 0); tick(); rst = 1'b0;
    drive(mk(1, 14, 0, 3, 2, 0), 0, 0, 0, 0);
    checks++; if (hif.sb_pending !== 16'h0 || hif.flush !== 1'b0 || hif.stall !== 1'b0) begin
      errors++; $display("FAIL mid_reset sb=%h flush=%b stall=%b required 0000 0 0", hif.sb_pending, hif.flush, hif.stall); end
    tick();
    drive(32'h0, 0, 1, 4'h2, 0); tick();
  endtask

  task automatic test_random();
    int opcs [6] = '{0, 1, 2, 3, 16, 5};
    logic [31:0] i; logic wv, ovf; logic [3:0] rc;
    int q [$];
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) i = 32'h0;
      else i = mk($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15),
                  opcs[$urandom_range(0, 5)], ($urandom_range(0, 15) == 0) ? 14 : $urandom_range(0, 15),
                  ($urandom_range(0, 7) == 0));
      q.delete();
      for (int b = 0; b < 14; b++) if (m_pend[b]) q.push_back(b);
      wv = 1'b0; rc = 4'hF; ovf = 1'b0;
      if (m_mode == 1 && $urandom_range(0, 3) == 0) begin wv = 1'b1; rc = 4'hE; end
      else if ($urandom_range(0, 1) == 1) begin
        if (q.size() > 0) rc = 4'(q[$urandom_range(0, q.size() - 1)]);
        ovf = m_pend[15] && ($urandom_range(0, 1) == 1);
        wv = (q.size() > 0) || ovf;
      end
      drive(i, ($urandom_range(0, 7) == 0), wv, rc, ovf);
      checks++; if (hif.stall !== m_stall) begin errors++; $display("FAIL rnd_stall cyc=%0d got=%b required=%b", c, hif.stall, m_stall); end
      tick();
      checks++; if (hif.sb_pending !== m_pend) begin errors++; $display("FAIL rnd_sb cyc=%0d got=%h required=%h", c, hif.sb_pending, m_pend); end
      checks++; if (hif.flush !== (m_mode == 2)) begin errors++; $display("FAIL rnd_flush cyc=%0d got=%b required=%b", c, hif.flush, m_mode == 2); end
      checks++; if (hif.stall_count !== m_cnt) begin errors++; $display("FAIL rnd_count cyc=%0d got=%0d required=%0d", c, hif.stall_count, m_cnt); end
    end
    rst = 1'b0;
  endtask

  initial begin
    m_pend = '0; m_mode = 0; m_left = 0; m_cnt = 0;
    test_reset();
    test_raw();
    test_imm();
    test_jump();
    test_mem_busy();
    test_ovf();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_control.md
# hazard_control

Issue controller for the decode stage of the pipelined core. Tracks outstanding register writes in a scoreboard and decides each cycle whether the instruction in decode may issue. Stalls issue on read-after-write, write-after-write, external memory busy and unresolved PC writes. Generates a flush pulse train once a PC write retires, so that wrong-path instructions are discarded.

## Interface
- `FLUSH_CYCLES`, default 2: number of cycles `flush` is held after a PC write retires (range 1–7).
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `instr_dec`  in  32  instruction currently in decode. `32'h0` is a bubble.
- `mem_busy`  in  1  memory stage cannot accept; forces stall.
- `wb_valid`  in  1  writeback retires an instruction this cycle.
- `wb_rc`  in  4  destination of the retiring instruction.
- `wb_ovf`  in  1  retiring instruction wrote the overflow register.
- `stall`  out  1  combinational; hold fetch and decode, decode emits a bubble.
- `flush`  out  1  registered; kill fetch/decode contents.
- `sb_pending`  out  16  registered scoreboard, for debug.
- `stall_count`  out  32  registered count of cycles with `stall`=1.

## Operation
- **Field decode**
  - Imb = [31], Ra = [30:27], Rb = [26:23], Opc = [12:8], Rc = [7:4], Cmp = [0].
  - Rb is a source only when Imb = 0 and Rb < 4'hE.
  - Ra is a source when Ra ≠ 4'hE. PC reads never hazard. Ra = 4'hF reads overflow (bit 15).
- **Writes**
  - An instruction writes Rc when it is not a bubble, Cmp = 0, Opc ≠ OPC_STORE and Rc ≠ 4'hF.
  - It writes overflow (bit 15) when `writes_ovf(Opc)` is true.
  - Rc = 4'hE is a PC write (jump).
- **Scoreboard**: bits 0–13 map to r0–r13, bit 14 is unused (always 0), bit 15 is overflow.
- **Issue**: the instruction issues in a cycle when it is not a bubble, `stall` = 0 and `flush` = 0. On issue, the destination bits are set.
- **Retire**
  - `wb_valid` clears bit `wb_rc` when `wb_rc` < 4'hE. A clear of bit 14 is ignored.
  - `wb_valid` with `wb_ovf` clears bit 15.
  - A set and a clear of different bits in the same cycle both take effect.
  - A set and a clear of the same bit in the same cycle cannot occur, because WAW stalls prevent it. The verification bench flags it as an error.
- **`stall`** = not rst and not bubble and any of:
  - `mem_busy`;
  - a source bit is pending;
  - the destination or overflow bit is pending (WAW);
  - state ≠ RUN.
- `stall` is computed from the registered scoreboard only. A same-cycle retire does not bypass it, which costs one extra stall cycle.
- **State machine**
  - RUN: issuing a PC write goes to WAIT_PC.
  - WAIT_PC: all issue is stalled. `wb_valid` with `wb_rc` = 4'hE goes to FLUSH and loads the counter with FLUSH_CYCLES−1.
  - FLUSH: `flush` = 1. The counter decrements each cycle. At 0, go to RUN.
  - Retires in WAIT_PC/FLUSH still clear scoreboard bits.
- **`stall_count`**: increments on every cycle with `stall` = 1 and wraps at 2^32.

## Timing
- Reset values:
  - scoreboard 0;
  - state RUN;
  - `flush` 0;
  - `stall_count` 0;
  - `stall` forced 0 during rst.
- Reset mid-operation discards all pending bits and any flush in progress.
- The scoreboard set is visible on the cycle after issue. A dependent instruction in the next cycle stalls.
- Retire at cycle N makes the bit clear at N+1; a stalled consumer issues at N+1.
- PC write: `flush` rises the cycle after the retire of `wb_rc` = 4'hE. It is high for exactly FLUSH_CYCLES cycles, then RUN resumes on the next cycle.
- `mem_busy` affects `stall` combinationally in the same cycle.

## Structure
- **Shared package `cpu_pkg`** holds:
  - field position constants;
  - REG_PC = 4'hE, REG_OVF = 4'hF, OPC_STORE;
  - the `writes_ovf(opc)` function;
  - the state typedef `hz_state_t` {RUN, WAIT_PC, FLUSH}.
- **Sub-module `hazard_scoreboard`**: the 16-bit pending register with set/clear ports and the registered `sb_pending` output.
- **`hazard_control`**: field decode, stall logic, FSM and counter.

## Test plan
- **RAW dependency**: issue r3 ← op, then an instruction with Ra = 3. The second stalls until `wb_valid` with `wb_rc` = 3, and issues the cycle after.
- **Immediate form**: Imb = 1 with bits [26:23] = 3 while r3 is pending → no stall. The same with Imb = 0 → stall.
- **Jump**: issue Rc = 4'hE, then retire it 4 cycles later. `stall` = 1 throughout WAIT_PC, then `flush` = 1 for exactly 2 cycles (default), then RUN.
- **Memory busy**: `mem_busy` high for 5 cycles with no hazards → `stall` = 1 for 5 cycles and `stall_count` = 5.
- **Overflow**: a `writes_ovf` op, then a reader with Ra = 4'hF. It stalls until `wb_ovf`. A simultaneous retire of r2 and issue setting r5 leaves only bit 5 set.
- **Reset mid-operation**: assert `rst` in WAIT_PC with bits 1 and 7 pending → scoreboard 0, state RUN, `flush` 0 on the next cycle.
